// File: rtl/ram_bus_pkg.sv
// Shared types and constants for the RAM bus initiator.
// States, default bus widths and the per-state strobe vectors {cs, rd, wr, oe}.
// The VF states are only reached when RAM_BUS_MASTER_VERIFY_EN is defined.
package ram_bus_pkg;

  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWr     = 3'd1,
    StRdAddr = 3'd2,
    StRdData = 3'd3,
    StVfAddr = 3'd4,
    StVfData = 3'd5
  } state_e;

  typedef struct packed {
    logic cs;
    logic rd;
    logic wr;
    logic oe;
  } strobe_t;

  // Strobe vectors {cs, rd, wr, oe}; oe is never set together with rd.
  localparam strobe_t STB_IDLE = 4'b0000;
  localparam strobe_t STB_WR   = 4'b1011;
  localparam strobe_t STB_RD   = 4'b1100;

  // Decode a state into its bus strobes; read-back states reuse the read pattern.
  function automatic strobe_t state_strobes(input state_e s);
    strobe_t stb;
    case (s)
      StWr:     stb = STB_WR;
      StRdAddr: stb = STB_RD;
      StRdData: stb = STB_RD;
      StVfAddr: stb = STB_RD;
      StVfData: stb = STB_RD;
      default:  stb = STB_IDLE;
    endcase
    return stb;
  endfunction

endpackage

// File: rtl/ram_bus_io.sv
// Tristate driver for the bidirectional RAM data bus.
// Drives dout onto mem_data while oe is high, otherwise releases the bus.
module ram_bus_io #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              oe,
  input  logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] din,
  inout  wire  [DATA_W-1:0] mem_data
);

  assign mem_data = oe ? dout : {DATA_W{1'bz}};
  assign din      = mem_data;

endmodule

// File: rtl/ram_bus_master.sv
// Initiator for the single-port synchronous RAM bus.
// Turns valid/ready requests into write cycles (WR) and two-cycle read cycles
// (RD_ADDR, RD_DATA) and returns read data on a one-cycle rsp_valid pulse.
// Optional macro RAM_BUS_MASTER_VERIFY_EN: every write is followed by a read-back
// (VF_ADDR, VF_DATA) that sets a sticky verify_err on mismatch.
// All mem_* outputs come from registered state and the latched request only.
module ram_bus_master
  import ram_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              verify_err,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic              mem_cs,
  output logic              mem_rd,
  output logic              mem_wr
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              accept;
  strobe_t           stb;
  logic              bus_oe;
  logic [DATA_W-1:0] bus_din;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid && req_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; every bus state lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = req_we ? StWr : StRdAddr;
        end
      end
`ifdef RAM_BUS_MASTER_VERIFY_EN
      StWr:     state_d = StVfAddr;
      StVfAddr: state_d = StVfData;
      StVfData: state_d = StIdle;
`else
      StWr:     state_d = StIdle;
`endif
      StRdAddr: state_d = StRdData;
      StRdData: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Latch the request on accept so later req_* changes cannot disturb the bus cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Capture read data at the closing edge of RD_DATA and pulse rsp_valid for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= (state_q == StRdData);
      if (state_q == StRdData) begin
        rsp_rdata_q <= bus_din;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

`ifdef RAM_BUS_MASTER_VERIFY_EN
  logic err_q;

  // Sticky flag: read-back data differs from the data just written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((state_q == StVfData) && (bus_din != wdata_q)) begin
      err_q <= 1'b1;
    end
  end

  assign verify_err = err_q;
`else
  assign verify_err = 1'b0;
`endif

  // Strobes are a pure decode of the state register.
  assign stb      = state_strobes(state_q);
  assign mem_cs   = stb.cs;
  assign mem_rd   = stb.rd;
  assign mem_wr   = stb.wr;
  assign bus_oe   = stb.oe;
  assign mem_addr = addr_q;

  ram_bus_io #(
    .DATA_W (DATA_W)
  ) u_io (
    .oe       (bus_oe),
    .dout     (wdata_q),
    .din      (bus_din),
    .mem_data (mem_data)
  );

endmodule

// File: tb/tb_ram_bus_master.sv
// Directed bench for ram_bus_master with a behavioural 1K x 8 synchronous RAM.
// Build with RAM_BUS_MASTER_VERIFY_EN to exercise the write read-back path.
module tb_ram_bus_master;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [9:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       verify_err;
  logic [9:0] mem_addr;
  wire  [7:0] mem_data;
  logic       mem_cs;
  logic       mem_rd;
  logic       mem_wr;

  int total = 0;
  int bad   = 0;
  int contention = 0;

  ram_bus_master dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .verify_err (verify_err),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_cs     (mem_cs),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: writes at the closing edge, read data registered then driven next cycle.
  logic [7:0] ram [1024];
  logic [7:0] ram_q;
  logic       ram_valid;
  logic       corrupt;

  always @(posedge clk) begin
    if (mem_cs && mem_wr) ram[mem_addr] <= mem_data;
    ram_valid <= mem_cs && mem_rd;
    if (mem_cs && mem_rd) ram_q <= ram[mem_addr] ^ (corrupt ? 8'hFF : 8'h00);
  end

  assign mem_data = (mem_cs && mem_rd && ram_valid) ? ram_q : 8'hzz;

  // Master must never drive while the RAM read strobe is up.
  always @(negedge clk) begin
    if (dut.bus_oe && mem_rd) contention++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request (master in IDLE) and drop req_valid after the accept edge.
  task automatic send(input logic we, input logic [9:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    corrupt   = 1'b0;
    ram_valid = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    chk("rst_verify_err", {31'd0, verify_err}, 32'd0);
    chk("rst_strobes", {29'd0, mem_cs, mem_rd, mem_wr}, 32'd0);
    chk("rst_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst_oe", {31'd0, dut.bus_oe}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write 0x000 <= 0xA5.
    send(1'b1, 10'h000, 8'hA5);
    @(negedge clk);
    chk("wr_ready", {31'd0, req_ready}, 32'd0);
    chk("wr_strobes", {29'd0, mem_cs, mem_rd, mem_wr}, 32'b101);
    chk("wr_oe", {31'd0, dut.bus_oe}, 32'd1);
    chk("wr_data", {24'd0, mem_data}, 32'hA5);
    chk("wr_addr", {22'd0, mem_addr}, 32'h000);
`ifdef RAM_BUS_MASTER_VERIFY_EN
    @(negedge clk);
    chk("vf_addr_strobes", {28'd0, mem_cs, mem_rd, mem_wr, dut.bus_oe}, 32'b1100);
    chk("vf_addr_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("vf_data_strobes", {28'd0, mem_cs, mem_rd, mem_wr, dut.bus_oe}, 32'b1100);
`endif
    @(negedge clk);
    chk("wr_done_ready", {31'd0, req_ready}, 32'd1);
    chk("wr_done_strobes", {29'd0, mem_cs, mem_rd, mem_wr}, 32'd0);
    chk("wr_ram0", {24'd0, ram[0]}, 32'hA5);
    chk("wr_no_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("wr_verify_err", {31'd0, verify_err}, 32'd0);

    // Read 0x000: two read-strobe cycles, then a single response pulse.
    send(1'b0, 10'h000, 8'h00);
    @(negedge clk);
    chk("rda_strobes", {28'd0, mem_cs, mem_rd, mem_wr, dut.bus_oe}, 32'b1100);
    chk("rda_ready", {31'd0, req_ready}, 32'd0);
    chk("rda_rsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("rdd_strobes", {28'd0, mem_cs, mem_rd, mem_wr, dut.bus_oe}, 32'b1100);
    chk("rdd_rsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rd_rsp_rdata", {24'd0, rsp_rdata}, 32'hA5);
    chk("rd_idle_cs", {31'd0, mem_cs}, 32'd0);
    @(negedge clk);
    chk("rd_rsp_pulse", {31'd0, rsp_valid}, 32'd0);

    // Back-to-back write 0x3FF <= 0x5A then read 0x3FF with req_valid held.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 10'h3FF;
    req_wdata = 8'h5A;
    @(posedge clk);
    #1;
    req_we    = 1'b0;
    req_wdata = 8'h00;
    @(negedge clk);
    chk("b2b_wr_data", {24'd0, mem_data}, 32'h5A);
    chk("b2b_wr_addr", {22'd0, mem_addr}, 32'h3FF);
`ifdef RAM_BUS_MASTER_VERIFY_EN
    repeat (2) @(negedge clk);
`endif
    @(negedge clk);
    chk("b2b_idle_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_rda", {28'd0, mem_cs, mem_rd, mem_wr, dut.bus_oe}, 32'b1100);
    chk("b2b_rd_addr", {22'd0, mem_addr}, 32'h3FF);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_rsp_rdata", {24'd0, rsp_rdata}, 32'h5A);
    chk("b2b_ram3ff", {24'd0, ram[10'h3FF]}, 32'h5A);

    // Reset during RD_DATA abandons the read.
    send(1'b0, 10'h3FF, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_rdd", {31'd0, mem_rd}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_strobes", {28'd0, mem_cs, mem_rd, mem_wr, dut.bus_oe}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_rsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("abort_rsp_hold", {31'd0, rsp_valid}, 32'd0);
    chk("abort_rdata_clr", {24'd0, rsp_rdata}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    send(1'b0, 10'h000, 8'h00);
    repeat (3) @(negedge clk);
    chk("post_rst_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("post_rst_rdata", {24'd0, rsp_rdata}, 32'hA5);

`ifdef RAM_BUS_MASTER_VERIFY_EN
    // Clean write with read-back.
    send(1'b1, 10'h010, 8'h3C);
    @(negedge clk);
    chk("vf_wr", {28'd0, mem_cs, mem_rd, mem_wr, dut.bus_oe}, 32'b1011);
    @(negedge clk);
    chk("vf_rd_addr", {22'd0, mem_addr}, 32'h010);
    chk("vf_rd_strobes", {28'd0, mem_cs, mem_rd, mem_wr, dut.bus_oe}, 32'b1100);
    @(negedge clk);
    chk("vf_busy", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("vf_ok_err", {31'd0, verify_err}, 32'd0);
    chk("vf_ok_no_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("vf_ok_ready", {31'd0, req_ready}, 32'd1);

    // Corrupted read-back sets the sticky flag.
    corrupt = 1'b1;
    send(1'b1, 10'h020, 8'h77);
    repeat (4) @(negedge clk);
    corrupt = 1'b0;
    chk("vf_bad_err", {31'd0, verify_err}, 32'd1);
    chk("vf_bad_no_rsp", {31'd0, rsp_valid}, 32'd0);
    send(1'b1, 10'h030, 8'h11);
    repeat (4) @(negedge clk);
    chk("vf_err_sticky", {31'd0, verify_err}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("vf_err_rst", {31'd0, verify_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`else
    send(1'b1, 10'h010, 8'h3C);
    @(negedge clk);
    @(negedge clk);
    chk("nvf_ready", {31'd0, req_ready}, 32'd1);
    chk("nvf_err", {31'd0, verify_err}, 32'd0);
    chk("nvf_ram", {24'd0, ram[10'h010]}, 32'h3C);
`endif
    @(negedge clk);

    chk("no_contention", contention, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
